// File: rtl/rsa_pkg.sv
// Shared definitions for the modular exponentiation engine.
//   - FSM state encodings (legacy-compatible localparam constants)
//   - default operand width
//   - latency helper functions (cycles from the accepting edge to done)
package rsa_pkg;

  localparam int unsigned DEFAULT_WIDTH = 32;
  localparam int unsigned STATE_W       = 3;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_CHECK  = 3'd1;
  localparam logic [2:0] ST_REDUCE = 3'd2;
  localparam logic [2:0] ST_MUL    = 3'd3;
  localparam logic [2:0] ST_SQR    = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;

  // Variable-time latency: one reduce, one multiply per set bit, one square per bit.
  function automatic int unsigned modexp_latency(input int unsigned width,
                                                 input int unsigned popcount,
                                                 input int unsigned bitlen);
    return 2 + (width + 1) * (1 + popcount + bitlen);
  endfunction

  // Constant-time latency: one reduce plus a multiply and a square for every bit.
  function automatic int unsigned modexp_latency_ct(input int unsigned width);
    return 2 + (width + 1) * (1 + 2 * width);
  endfunction

endpackage

// File: rtl/rsa_modmul.sv
// Serial interleaved modular multiplier: p = a*b mod n, requires b < n.
// One load cycle (go) followed by WIDTH MSB-first iterations over a;
// valid pulses for one cycle once p holds the final product.
// Ports:
//   clk, reset   clock, async active-high reset
//   go           load operands and start (ignored operands while busy not expected)
//   a, b, n      multiplicand (any value), multiplier (< n), modulus
//   busy         iterations in progress
//   valid        one-cycle pulse, p is the product
//   p            product register
module rsa_modmul
  import rsa_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] n,
  output logic             busy,
  output logic             valid,
  output logic [WIDTH-1:0] p
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] n_q;
  logic [WIDTH-1:0] acc;
  logic [CNT_W-1:0] cnt;

  logic [WIDTH+1:0] t;
  logic [WIDTH+1:0] t1;
  logic [WIDTH+1:0] nx;
  logic [WIDTH-1:0] acc_nxt;

  // R = 2R + a_i*b stays below 3n, so two conditional subtractions restore R < n.
  always_comb begin
    nx      = {2'b00, n_q};
    t       = {1'b0, acc, 1'b0} + (a_q[WIDTH-1] ? {2'b00, b_q} : '0);
    t1      = (t >= nx) ? (t - nx) : t;
    acc_nxt = (t1 >= nx) ? WIDTH'(t1 - nx) : WIDTH'(t1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q   <= '0;
      b_q   <= '0;
      n_q   <= '0;
      acc   <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
      valid <= 1'b0;
    end else if (go) begin
      a_q   <= a;
      b_q   <= b;
      n_q   <= n;
      acc   <= '0;
      cnt   <= CNT_W'(WIDTH);
      busy  <= 1'b1;
      valid <= 1'b0;
    end else if (busy) begin
      acc <= acc_nxt;
      a_q <= a_q << 1;
      cnt <= cnt - CNT_W'(1);
      if (cnt == CNT_W'(1)) begin
        busy  <= 1'b0;
        valid <= 1'b1;
      end
    end else begin
      valid <= 1'b0;
    end
  end

  assign p = acc;

endmodule

// File: rtl/rsa_modexp_param.sv
// Handshake-driven modular exponentiation: result = message^exponent mod modulus.
// Right-to-left square-and-multiply sequenced around one serial rsa_modmul.
// Build option: define RSA_MODEXP_CONST_TIME_EN for fixed latency (every bit
// runs a multiply and a square; unused products land in a dummy register).
// Ports:
//   clk, reset                   clock, async active-high reset
//   start                        request, sampled only while ready=1
//   message, exponent, modulus   operands, captured on the accepting edge
//   ready                        idle and accepting start
//   done                         one-cycle pulse, result/err valid
//   err                          modulus < 2
//   result                       exponentiation result, held until next job
module rsa_modexp_param
  import rsa_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] message,
  input  logic [WIDTH-1:0] exponent,
  input  logic [WIDTH-1:0] modulus,
  output logic             ready,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] result
);

  logic [STATE_W-1:0] state, state_d;
  logic [WIDTH-1:0]   msg_q, msg_d;
  logic [WIDTH-1:0]   exp_q, exp_d;
  logic [WIDTH-1:0]   mod_q, mod_d;
  logic [WIDTH-1:0]   r_q, r_d;
  logic [WIDTH-1:0]   base_q, base_d;
  logic               flag_q, flag_d;
  logic               ready_d, done_d, err_d;
  logic [WIDTH-1:0]   result_d;
  logic               do_test;
  logic               go_req;

`ifdef RSA_MODEXP_CONST_TIME_EN
  localparam int unsigned BITS_W = $clog2(WIDTH + 1);
  logic [BITS_W-1:0] bits_q, bits_d;
  logic [WIDTH-1:0]  dummy_q, dummy_d;
`endif

  logic             mm_go;
  logic             mm_busy;
  logic             mm_valid;
  logic [WIDTH-1:0] mm_a;
  logic [WIDTH-1:0] mm_b;
  logic [WIDTH-1:0] mm_p;

  rsa_modmul #(.WIDTH(WIDTH)) u_modmul (
    .clk   (clk),
    .reset (reset),
    .go    (mm_go),
    .a     (mm_a),
    .b     (mm_b),
    .n     (mod_q),
    .busy  (mm_busy),
    .valid (mm_valid),
    .p     (mm_p)
  );

  // Next-state / next-register logic; the next multiply is launched on the same
  // edge the previous product is written, so operands come from the _d values.
  always_comb begin
    state_d  = state;
    msg_d    = msg_q;
    exp_d    = exp_q;
    mod_d    = mod_q;
    r_d      = r_q;
    base_d   = base_q;
    flag_d   = flag_q;
    ready_d  = ready;
    done_d   = 1'b0;
    err_d    = err;
    result_d = result;
    do_test  = 1'b0;
    go_req   = 1'b0;
`ifdef RSA_MODEXP_CONST_TIME_EN
    bits_d   = bits_q;
    dummy_d  = dummy_q;
`endif

    case (state)
      ST_IDLE: begin
        ready_d = 1'b1;
        if (start && ready) begin
          msg_d   = message;
          exp_d   = exponent;
          mod_d   = modulus;
          ready_d = 1'b0;
          state_d = ST_CHECK;
`ifdef RSA_MODEXP_CONST_TIME_EN
          bits_d  = BITS_W'(WIDTH);
`endif
        end
      end
      ST_CHECK: begin
        if (mod_q < WIDTH'(2)) begin
          flag_d  = 1'b1;
          r_d     = '0;
          state_d = ST_DONE;
        end else begin
          flag_d  = 1'b0;
          r_d     = WIDTH'(1);
          state_d = ST_REDUCE;
          go_req  = 1'b1;
        end
      end
      ST_REDUCE: begin
        if (mm_valid) begin
          base_d  = mm_p;
          do_test = 1'b1;
        end
      end
      ST_MUL: begin
        if (mm_valid) begin
`ifdef RSA_MODEXP_CONST_TIME_EN
          if (exp_q[0]) r_d = mm_p;
          else          dummy_d = mm_p;
`else
          r_d = mm_p;
`endif
          state_d = ST_SQR;
          go_req  = 1'b1;
        end
      end
      ST_SQR: begin
        if (mm_valid) begin
          base_d  = mm_p;
          exp_d   = exp_q >> 1;
`ifdef RSA_MODEXP_CONST_TIME_EN
          bits_d  = bits_q - BITS_W'(1);
`endif
          do_test = 1'b1;
        end
      end
      ST_DONE: begin
        done_d   = 1'b1;
        result_d = r_q;
        err_d    = flag_q;
        state_d  = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        ready_d = 1'b1;
      end
    endcase

    // Exponent-bit decision folded into the transition out of REDUCE/SQR.
    if (do_test) begin
`ifdef RSA_MODEXP_CONST_TIME_EN
      if (bits_d == '0) begin
        state_d = ST_DONE;
      end else begin
        state_d = ST_MUL;
        go_req  = 1'b1;
      end
`else
      if (exp_d == '0) begin
        state_d = ST_DONE;
      end else if (exp_d[0]) begin
        state_d = ST_MUL;
        go_req  = 1'b1;
      end else begin
        state_d = ST_SQR;
        go_req  = 1'b1;
      end
`endif
    end

    mm_go = go_req & ~mm_busy;
    mm_a  = (state_d == ST_REDUCE) ? msg_q : base_d;
    if (state_d == ST_REDUCE)   mm_b = WIDTH'(1);
    else if (state_d == ST_MUL) mm_b = r_d;
    else                        mm_b = base_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= ST_IDLE;
      msg_q  <= '0;
      exp_q  <= '0;
      mod_q  <= '0;
      r_q    <= '0;
      base_q <= '0;
      flag_q <= 1'b0;
      ready  <= 1'b1;
      done   <= 1'b0;
      err    <= 1'b0;
      result <= '0;
`ifdef RSA_MODEXP_CONST_TIME_EN
      bits_q  <= '0;
      dummy_q <= '0;
`endif
    end else begin
      state  <= state_d;
      msg_q  <= msg_d;
      exp_q  <= exp_d;
      mod_q  <= mod_d;
      r_q    <= r_d;
      base_q <= base_d;
      flag_q <= flag_d;
      ready  <= ready_d;
      done   <= done_d;
      err    <= err_d;
      result <= result_d;
`ifdef RSA_MODEXP_CONST_TIME_EN
      bits_q  <= bits_d;
      dummy_q <= dummy_d;
`endif
    end
  end

endmodule

// File: tb/tb_rsa_modexp_param.sv
// Directed testbench for rsa_modexp_param (WIDTH=32): hand-computed results,
// exact done latency, error path, ignored start while busy, mid-job reset.
module tb_rsa_modexp_param;

  localparam int M     = 33;
  localparam int LIMIT = 3000;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] message;
  logic [31:0] exponent;
  logic [31:0] modulus;
  logic        ready;
  logic        done;
  logic        err;
  logic [31:0] result;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rsa_modexp_param #(.WIDTH(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .message  (message),
    .exponent (exponent),
    .modulus  (modulus),
    .ready    (ready),
    .done     (done),
    .err      (err),
    .result   (result)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int lat(input int pop, input int bl);
    int v;
    v = 2 + M * (1 + pop + bl);
`ifdef RSA_MODEXP_CONST_TIME_EN
    v = 2 + M * 65;
`endif
    return v;
  endfunction

  // Runs one job; cycle 0 is the accepting edge, latency counts edges to done.
  task automatic run_job(input string tag, input logic [31:0] m, input logic [31:0] e,
                         input logic [31:0] n, input logic [31:0] exp_res,
                         input logic exp_err, input int exp_lat, input bit poke);
    int cyc;
    int w;
    w = 0;
    while (!ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    @(negedge clk);
    start    = 1'b1;
    message  = m;
    exponent = e;
    modulus  = n;
    @(posedge clk);
    #1;
    start    = 1'b0;
    message  = 32'hFFFF_FFFF;
    exponent = 32'h0000_00FF;
    modulus  = 32'd3;
    check_eq({tag, "_ready_low"}, 64'(ready), 64'd0);
    cyc = 0;
    while (!done && cyc < LIMIT) begin
      if (poke && cyc == 10) begin
        start    = 1'b1;
        message  = 32'd5;
        exponent = 32'd3;
        modulus  = 32'd11;
      end
      if (poke && cyc == 11) start = 1'b0;
      @(posedge clk);
      #1;
      cyc++;
    end
    start = 1'b0;
    check_eq({tag, "_done_seen"}, 64'(done), 64'd1);
    check_eq({tag, "_latency"}, 64'(cyc), 64'(exp_lat));
    check_eq({tag, "_result"}, 64'(result), 64'(exp_res));
    check_eq({tag, "_err"}, 64'(err), 64'(exp_err));
    @(posedge clk);
    #1;
    check_eq({tag, "_done_pulse"}, 64'(done), 64'd0);
    check_eq({tag, "_ready_back"}, 64'(ready), 64'd1);
  endtask

  initial begin
    int saw_done;
    reset    = 1'b0;
    start    = 1'b0;
    message  = '0;
    exponent = '0;
    modulus  = '0;
    #2;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_ready", 64'(ready), 64'd1);
    check_eq("rst_done", 64'(done), 64'd0);
    check_eq("rst_err", 64'(err), 64'd0);
    check_eq("rst_result", 64'(result), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    run_job("base",     32'd4,   32'd13, 32'd497,  32'd445, 1'b0, lat(3, 4), 1'b0);
    run_job("msg_ge_n", 32'd500, 32'd2,  32'd497,  32'd9,   1'b0, lat(1, 2), 1'b0);
    run_job("even_n",   32'd2,   32'd10, 32'd1000, 32'd24,  1'b0, lat(2, 4), 1'b0);
    run_job("exp0",     32'd123, 32'd0,  32'd7,    32'd1,   1'b0, lat(0, 0), 1'b0);
    run_job("msg0",     32'd0,   32'd5,  32'd7,    32'd0,   1'b0, lat(2, 3), 1'b0);
    run_job("n1",       32'd5,   32'd3,  32'd1,    32'd0,   1'b1, 2,         1'b0);
    run_job("n0",       32'd9,   32'd7,  32'd0,    32'd0,   1'b1, 2,         1'b0);
    run_job("after_err",32'd3,   32'd5,  32'd7,    32'd5,   1'b0, lat(2, 3), 1'b0);
    run_job("poke",     32'd4,   32'd13, 32'd497,  32'd445, 1'b0, lat(3, 4), 1'b1);

    // Reset in the first square (cycles 67..100 of this job); no done may escape.
    @(negedge clk);
    start    = 1'b1;
    message  = 32'd4;
    exponent = 32'd13;
    modulus  = 32'd497;
    @(posedge clk);
    #1;
    start = 1'b0;
    saw_done = 0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk);
      #1;
      if (done) saw_done++;
    end
    reset = 1'b1;
    #1;
    check_eq("midrst_ready_async", 64'(ready), 64'd1);
    check_eq("midrst_done_async", 64'(done), 64'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check_eq("midrst_ready_after", 64'(ready), 64'd1);
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      #1;
      if (done) saw_done++;
    end
    check_eq("midrst_no_done", 64'(saw_done), 64'd0);
    run_job("post_rst", 32'd3, 32'd5, 32'd7, 32'd5, 1'b0, lat(2, 3), 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rsa_modexp_param.md
Name: rsa_modexp_param

Overview:
Parametrised, handshake-driven modular exponentiation engine computing result = message^exponent mod modulus for the RSA datapath. It is the next generation of the fixed 32-bit free-running encryptor:
- Operand width is a parameter.
- Work is started by an explicit start/ready handshake and signalled by a done pulse.
- Products are formed by a serial interleaved modular multiplier instead of full-width multiply plus `%`.
- Degenerate moduli are flagged.

Parameters:
WIDTH, 32, operand width in bits (message, exponent, modulus, result); legal range 8..2048.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  request pulse; sampled only while ready=1
message  in  WIDTH  base operand; any value, including >= modulus
exponent  in  WIDTH  exponent operand
modulus  in  WIDTH  modulus operand
ready  out  1  engine idle, will accept start
done  out  1  one-cycle pulse, result/err valid
err  out  1  valid with done; 1 = modulus < 2
result  out  WIDTH  exponentiation result; held until next accepted start

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high.
- Reset values: ready=1, done=0, err=0, result=0, state IDLE.
- Reset mid-operation: aborts with no done pulse. ready=1 from the first clk edge after reset deasserts.
- Handshake:
  - start && ready at a rising edge captures message, exponent and modulus, and drops ready the same edge.
  - start while ready=0 is ignored; no queueing.
  - Inputs may change freely after capture.
- States:
  - IDLE: wait for start.
  - CHECK (1 cycle):
    - If modulus < 2: go to DONE with err=1, result=0.
    - Else: r=1, go to REDUCE.
  - REDUCE (M cycles): base = modmul(message, 1) = message mod n.
  - TEST (0-cycle decision folded into the preceding transition):
    - If exponent==0: go to DONE.
    - Else if exponent[0]: go to MUL.
    - Else: go to SQR.
  - MUL (M cycles): r = modmul(base, r).
  - SQR (M cycles): base = modmul(base, base); then exponent >>= 1, return to TEST.
  - DONE (1 cycle): result <= r, err <= flag, done=1. Next cycle ready=1 and done=0.
- Multiplier cost: M = WIDTH+1 cycles per modmul (1 load + WIDTH iterations).
- Latency: from the accepting edge, done is high at cycle 2 + M*(1 + popcount(e) + bitlen(e)), where bitlen(0)=0.
  - Example, e=0: done at cycle 2+M with result=1.
  - err path: done at cycle 2.
- modmul(a,b) requires b < n and returns a*b mod n. Algorithm, MSB-first over a:
  - R = 2R + a_i*b, then conditionally subtract n up to twice.
  - Internal R is WIDTH+2 bits wide, so there is no overflow for any WIDTH.
  - Even and odd moduli are both supported.
- result is always < modulus when err=0.

Optional Feature:
Macro RSA_MODEXP_CONST_TIME_EN.
- Defined:
  - The loop always runs exactly WIDTH iterations regardless of leading zeros.
  - MUL always executes. When exponent[0]=0 its product goes to a discarded dummy register.
  - Latency is fixed at 2 + M*(1 + 2*WIDTH). The err path stays at 2 cycles.
- Undefined: variable latency as above.
- Results are identical in both builds.

Decomposition:
- Shared package rsa_pkg holds:
  - state encoding localparams (IDLE, CHECK, REDUCE, MUL, SQR, DONE);
  - the default WIDTH;
  - the latency helper constant function.
- One sub-module, rsa_modmul: parameter WIDTH. Interface:
  - inputs clk, reset, go, a, b, n;
  - outputs busy, valid (pulse after WIDTH+1 cycles), p.
- The top-level FSM owns the sequencing and the r/base/exponent registers and instantiates rsa_modmul once.

Test Plan:
- WIDTH=32, m=4, e=13, n=497 -> done with result=445, err=0. Done at cycle 2+33*(1+3+4)=266.
- m=500, e=2, n=497 (message >= modulus) -> result=9. Also m=2, e=10, n=1000 -> 24 (even modulus).
- e=0, m=123, n=7 -> result=1 at cycle 35. Also m=0, e=5, n=7 -> result=0.
- n=1, then n=0 -> done at cycle 2 with err=1, result=0. The next valid job completes normally.
- start pulsed again mid-job with different operands -> ignored; the original result (445) is returned and only one done pulse occurs.
- reset asserted mid-SQR -> no done pulse, ready=1 after release. A new job m=3, e=5, n=7 returns 5.
- With RSA_MODEXP_CONST_TIME_EN: the first and third scenarios each finish at exactly 2+33*65=2147 cycles, with results unchanged.
